// File: rtl/bitvector_deserializer.sv
// Serial-to-parallel deserializer: collects COUNT_OF_BITS serial bits LSB-first
// into a word and presents it on a valid/ready output port. A two-state FSM
// parks a completed word in the shift register while the output slot is busy.
module bitvector_deserializer #(
    parameter int COUNT_OF_BITS = 4,
    localparam int CW = $clog2(COUNT_OF_BITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_bit,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [COUNT_OF_BITS-1:0] bitvector,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            bit_count
);

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [CW-1:0] FULL_COUNT = CW'(COUNT_OF_BITS);
    localparam logic [CW-1:0] LAST_COUNT = CW'(COUNT_OF_BITS - 1);

    state_t                   state, state_next;
    logic [COUNT_OF_BITS-1:0] shift_reg, shift_next;
    logic [COUNT_OF_BITS-1:0] bitvector_next;
    logic                     out_valid_next;
    logic [CW-1:0]            bit_count_next;

    logic accept;
    logic slot_free;
    logic last_bit;

    // in_ready is a pure decode of the registered state
    assign in_ready  = (state == COLLECT);
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign last_bit  = (bit_count == LAST_COUNT);

    // Next-state and datapath decode; every target defaults to holding its value
    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        bitvector_next = bitvector;
        bit_count_next = bit_count;
        // A consumed word empties the slot unless a new word replaces it below
        out_valid_next = (out_valid && out_ready) ? 1'b0 : out_valid;

        case (state)
            COLLECT: begin
                if (accept) begin
                    // New bits enter at the top so the first bit ends up in [0]
                    shift_next = {in_bit, shift_reg[COUNT_OF_BITS-1:1]};
                    if (last_bit) begin
                        if (slot_free) begin
                            bitvector_next = shift_next;
                            out_valid_next = 1'b1;
                            bit_count_next = '0;
                        end else begin
                            // Word is complete but the slot is busy: park it
                            bit_count_next = FULL_COUNT;
                            state_next     = HOLD;
                        end
                    end else begin
                        bit_count_next = bit_count + CW'(1);
                    end
                end
            end
            HOLD: begin
                // out_valid is necessarily 1 here; release the parked word
                if (out_ready) begin
                    bitvector_next = shift_reg;
                    out_valid_next = 1'b1;
                    bit_count_next = '0;
                    state_next     = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // State and output registers, cleared immediately on reset assertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            shift_reg <= '0;
            bitvector <= '0;
            out_valid <= 1'b0;
            bit_count <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bitvector <= bitvector_next;
            out_valid <= out_valid_next;
            bit_count <= bit_count_next;
        end
    end

endmodule

// File: doc/bitvector_deserializer.md
BITVECTOR_DESERIALIZER -- requirements
Module: bitvector_deserializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter COUNT_OF_BITS, default 4, SHALL set the output word width; legal values are >= 2.
REQ-003 Derived width CW SHALL equal $clog2(COUNT_OF_BITS+1).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous reset, active low.
REQ-006 Port: in_bit  input  1  serial data bit.
REQ-007 Port: in_valid  input  1  in_bit is valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts in_bit this cycle.
REQ-009 Port: bitvector  output  COUNT_OF_BITS  assembled word, which feeds the downstream reduce stage.
REQ-010 Port: out_valid  output  1  bitvector holds a complete word.
REQ-011 Port: out_ready  input  1  consumer takes bitvector this cycle.
REQ-012 Port: bit_count  output  CW  bits held in the shift register (0..COUNT_OF_BITS).

Function
REQ-013 An input transfer SHALL occur on a rising edge where in_valid && in_ready; an output transfer SHALL occur where out_valid && out_ready.
REQ-014 Bits SHALL be packed LSB-first: the first accepted bit of a word lands in bitvector[0], and the last lands in bitvector[COUNT_OF_BITS-1].
REQ-015 Internal state SHALL be a shift register, bit_count, and a two-state FSM {COLLECT, HOLD}.
REQ-016 in_ready SHALL be 1 in COLLECT and 0 in HOLD, decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-017 COLLECT, accepted bit with bit_count < COUNT_OF_BITS-1: shift the bit in and increment bit_count.
REQ-018 COLLECT, accepted bit that completes the word, with output slot free (!out_valid || out_ready): on that edge, load the full word into bitvector, set out_valid=1, set bit_count=0, and stay in COLLECT.
REQ-019 COLLECT, accepted bit that completes the word, with output slot busy (out_valid && !out_ready): store the bit, set bit_count=COUNT_OF_BITS, and go to HOLD; bitvector SHALL remain unchanged.
REQ-020 HOLD, on the edge with out_ready=1: load the held word into bitvector, keep out_valid=1, set bit_count=0, and go to COLLECT.
REQ-021 HOLD, out_ready=0: all state SHALL be held.
REQ-022 Output transfer with no new word loading that edge: out_valid SHALL go to 0 and bitvector SHALL hold its last value.
REQ-023 Word completion and output consumption in the same cycle SHALL give back-to-back words with no bubble on out_valid.
REQ-024 bitvector and out_valid SHALL be stable while out_valid && !out_ready.
REQ-025 in_bit SHALL be ignored when in_valid=0 or in_ready=0; gaps in in_valid SHALL not corrupt the partial word.
REQ-026 Latency SHALL be: out_valid rises on the same edge that accepts the last bit of a word, when the slot is free.
REQ-027 Throughput SHALL be one bit per cycle sustained while out_ready keeps pace.
REQ-028 All outputs SHALL be registered, except in_ready, which is a decode of registered state.

Reset
REQ-029 While rst_n=0: out_valid=0, bitvector=0, bit_count=0, shift register=0, and state=COLLECT (so in_ready=1); inputs are ignored.
REQ-030 Reset assertion mid-word or in HOLD SHALL discard the partial word, the held word and the output word immediately, without waiting for a clock edge.
REQ-031 After rst_n deasserts, the first accepted bit SHALL be bit 0 of a fresh word.

Verification (COUNT_OF_BITS=4)
REQ-032 Reset: assert rst_n=0 asynchronously mid-cycle -> immediately out_valid=0, bitvector=4'b0000, bit_count=0, in_ready=1.
REQ-033 Basic: out_ready=1, bits 1,0,1,1 on consecutive cycles -> on the 4th accept edge out_valid=1 and bitvector=4'b1101; next edge out_valid=0.
REQ-034 Backpressure: out_ready=0, word 1,1,1,1 then bits 1,1,0,0 -> first word bitvector=4'b1111; after the 4th bit of the second word in_ready=0 (HOLD) and bit_count=4; raise out_ready -> next edge bitvector=4'b0011, in_ready=1, bit_count=0.
REQ-035 Gaps: bits 0,1,1,0 with in_valid low for 3 cycles between each bit -> bitvector=4'b0110, and idle cycles leave bit_count unchanged.
REQ-036 Mid-word reset: accept 2 bits, pulse rst_n low, then send 1,0,0,1 -> bitvector=4'b1001 with no residue from the first 2 bits.
REQ-037 No-bubble: out_valid=1 and out_ready=1 on the edge accepting the 4th bit of word 1,0,0,0 -> out_valid stays 1 and bitvector=4'b0001 on that edge.
